// File: rtl/sevenseg_scan.sv
// sevenseg_scan
// Time-multiplexed seven-segment display driver. It captures an NDIG-digit
// packed nibble value into a pending buffer, then copies it to the display
// buffer only at a frame boundary, so a frame never shows a half-updated
// number. Each digit gets one slot of DIV cycles. The first GAP cycles of a
// slot keep every anode off to prevent ghosting.
//
// Ports:
//   clk        - single rising-edge clock
//   rst        - synchronous active-high reset
//   load       - capture value/dp_in into the pending buffer this cycle
//   value      - packed digits, digit i = value[4i+3:4i], digit 0 least significant
//   dp_in      - decimal point per digit
//   blank_lz   - leading-zero blanking enable, sampled live
//   seg        - segments {a,b,c,d,e,f,g}, registered, polarity per SEG_ACT_LOW
//   dp         - decimal point of the scanned digit, polarity per SEG_ACT_LOW
//   an         - per-digit anode enables, one-hot when active, polarity per AN_ACT_LOW
//   frame_done - one-cycle pulse on the last cycle of the last digit's slot
//   upd_ack    - one-cycle pulse when pending contents reach the display buffer
module sevenseg_scan #(
  parameter int NDIG        = 4,
  parameter int DIV         = 1000,
  parameter int GAP         = 2,
  parameter int HEX_EN      = 1,
  parameter int SEG_ACT_LOW = 0,
  parameter int AN_ACT_LOW  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              frame_done,
  output logic              upd_ack
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_C   = CW'(GAP);
  localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);
  localparam logic SEG_INV = (SEG_ACT_LOW != 0);
  localparam logic AN_INV  = (AN_ACT_LOW != 0);
  localparam logic HEX_ON  = (HEX_EN != 0);

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] disp_val;
  logic [NDIG-1:0]   disp_dp;
  logic [4*NDIG-1:0] pend_val;
  logic [NDIG-1:0]   pend_dp;
  logic              pend_flag;

  logic              tick;
  logic              boundary;
  logic [NDIG-1:0]   blanked;
  logic              zero_run;
  logic [3:0]        cur_digit;
  logic              cur_dp;
  logic              cur_blank;
  logic              active;
  logic [6:0]        seg_next;
  logic              dp_next;
  logic [NDIG-1:0]   an_next;

  // Active-high glyph for one nibble; codes 10..15 go blank when hex is off.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      4'hF: g = 7'b1000111;
      default: g = 7'b0000000;
    endcase
    if (!HEX_ON && d > 4'd9) g = 7'b0000000;
    return g;
  endfunction

  assign tick     = (cnt == CNT_MAX);
  assign boundary = tick && (idx == IDX_MAX);

  // Walk from the most significant digit down. A digit is blanked while it
  // and everything above it are zero. Digit 0 always shows.
  always_comb begin
    blanked  = '0;
    zero_run = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_run = zero_run && (disp_val[4*i +: 4] == 4'd0);
      if (i > 0) blanked[i] = blank_lz && zero_run;
    end
  end

  // Pick the digit under the scan and build the next registered output
  // values. They are still active-high at this point.
  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        cur_digit = disp_val[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_blank = blanked[i];
      end
    end
    active   = (cnt >= GAP_C) && !cur_blank;
    seg_next = active ? glyph(cur_digit) : 7'b0000000;
    dp_next  = active && cur_dp;
    an_next  = active ? (NDIG'(1) << idx) : '0;
  end

  // Prescaler, scan index, double buffer and registered pin outputs.
  // A load on the boundary cycle bypasses pending and goes straight to the
  // display buffer. Polarity inversion is the last step before the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_flag  <= 1'b0;
      seg        <= {7{SEG_INV}};
      dp         <= SEG_INV;
      an         <= {NDIG{AN_INV}};
      frame_done <= 1'b0;
      upd_ack    <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;

      if (boundary && load) begin
        pend_val  <= value;
        pend_dp   <= dp_in;
        disp_val  <= value;
        disp_dp   <= dp_in;
        pend_flag <= 1'b0;
      end else if (boundary && pend_flag) begin
        disp_val  <= pend_val;
        disp_dp   <= pend_dp;
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_val  <= value;
        pend_dp   <= dp_in;
        pend_flag <= 1'b1;
      end

      seg        <= seg_next ^ {7{SEG_INV}};
      dp         <= dp_next ^ SEG_INV;
      an         <= an_next ^ {NDIG{AN_INV}};
      frame_done <= boundary;
      upd_ack    <= boundary && (load || pend_flag);
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan
// Self-checking bench for sevenseg_scan with NDIG=4, DIV=8, GAP=2.
// Two instances share the same stimulus:
//   main - HEX_EN=1, active-high pins
//   alt  - HEX_EN=0, active-low segments and anodes
// The stimulus process queues the expected frame contents for each load
// that should become visible. The monitor pops one entry each time upd_ack
// is seen. It checks every complete frame against the current expectation,
// covering digit glyphs, active cycle counts, decimal points and idle
// cycles.
module tb_sevenseg_scan;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0][6:0] segs;
    logic [3:0]      act;
    logic [3:0]      dps;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;

  logic [6:0]  seg, alt_seg;
  logic        dp, alt_dp;
  logic [3:0]  an, alt_an;
  logic        frame_done, alt_frame_done;
  logic        upd_ack, alt_upd_ack;

  int tests_run = 0;
  int tests_failed = 0;
  int frame_pos = 0;

  frame_t exp_q[$];
  frame_t cur_exp;

  int         gap;
  int         cnt_obs[2][4];
  logic [6:0] seg_obs[2][4];
  logic       dp_obs[2][4];
  int         err_idle[2];
  int         err_hot[2];
  int         err_cons[2];

  sevenseg_scan #(.NDIG(4), .DIV(8), .GAP(2), .HEX_EN(1),
                  .SEG_ACT_LOW(0), .AN_ACT_LOW(0)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done), .upd_ack(upd_ack)
  );

  sevenseg_scan #(.NDIG(4), .DIV(8), .GAP(2), .HEX_EN(0),
                  .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) dut_alt (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .seg(alt_seg), .dp(alt_dp), .an(alt_an),
    .frame_done(alt_frame_done), .upd_ack(alt_upd_ack)
  );

  always #5 clk = ~clk;

  function automatic frame_t mkRec(input logic [15:0] v, input logic [27:0] s,
                                   input logic [3:0] a, input logic [3:0] p);
    frame_t r;
    r.value = v;
    r.segs  = s;
    r.act   = a;
    r.dps   = p;
    return r;
  endfunction

  // With hex glyphs disabled, any digit coded 10..15 lights no segments.
  function automatic logic [27:0] noHexSegs(input frame_t r);
    logic [27:0] o;
    for (int d = 0; d < 4; d++)
      o[7*d +: 7] = (r.value[4*d +: 4] > 4'd9) ? 7'b0000000 : r.segs[d];
    return o;
  endfunction

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input logic [6:0] s, input logic p,
                             input logic [3:0] a, input logic f, input logic u);
    cmp({name, "_main"}, {seg, dp, an, frame_done, upd_ack}, {s, p, a, f, u});
    cmp({name, "_alt"}, {alt_seg, alt_dp, alt_an, alt_frame_done, alt_upd_ack},
        {~s, ~p, ~a, f, u});
  endtask

  task automatic clearObs();
    for (int k = 0; k < 2; k++) begin
      err_idle[k] = 0;
      err_hot[k]  = 0;
      err_cons[k] = 0;
      for (int d = 0; d < 4; d++) begin
        cnt_obs[k][d] = 0;
        seg_obs[k][d] = 7'b0000000;
        dp_obs[k][d]  = 1'b0;
      end
    end
  endtask

  task automatic observe(input int k, input logic [6:0] s, input logic p, input logic [3:0] a);
    int d;
    if (a == 4'b0000) begin
      if (s != 7'b0000000 || p) err_idle[k]++;
    end else if (!$onehot(a)) begin
      err_hot[k]++;
    end else begin
      d = 0;
      for (int i = 0; i < 4; i++) if (a[i]) d = i;
      if (cnt_obs[k][d] == 0) begin
        seg_obs[k][d] = s;
        dp_obs[k][d]  = p;
      end else if (seg_obs[k][d] != s || dp_obs[k][d] != p) begin
        err_cons[k]++;
      end
      cnt_obs[k][d]++;
    end
  endtask

  // Monitor: accumulate one frame of pin activity for both instances (alt
  // pins are normalised to active-high). At each frame_done, compare the
  // frame and pop the next expectation if an update was acknowledged.
  always @(negedge clk) begin
    if (rst) begin
      gap = -1;
      clearObs();
      cur_exp = mkRec(16'h0000, {4{7'b1111110}}, 4'b1111, 4'b0000);
    end else begin
      gap++;
      observe(0, seg, dp, an);
      observe(1, ~alt_seg, ~alt_dp, ~alt_an);
      if (upd_ack) cmp("ack_with_frame_done", frame_done, 1'b1);
      if (frame_done || alt_frame_done)
        cmp("alt_pulses_match", {alt_frame_done, alt_upd_ack}, {frame_done, upd_ack});
      if (frame_done) begin
        cmp("frame_period", gap, 32);
        for (int k = 0; k < 2; k++) begin
          logic [27:0] es, os;
          logic [3:0]  od;
          logic [15:0] oc, ec;
          string tag;
          tag = (k == 0) ? "main" : "alt";
          es = (k == 0) ? cur_exp.segs : noHexSegs(cur_exp);
          for (int d = 0; d < 4; d++) begin
            os[7*d +: 7] = seg_obs[k][d];
            od[d]        = dp_obs[k][d];
            oc[4*d +: 4] = 4'(cnt_obs[k][d]);
            ec[4*d +: 4] = cur_exp.act[d] ? 4'd6 : 4'd0;
          end
          cmp({tag, "_active_cycles"}, oc, ec);
          cmp({tag, "_glyphs"}, os, es);
          cmp({tag, "_dps"}, od, cur_exp.dps);
          cmp({tag, "_idle_onehot_stable_errs"}, {err_idle[k], err_hot[k], err_cons[k]}, 0);
        end
        clearObs();
        gap = 0;
        if (upd_ack) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL ack_unexpected: got upd_ack=1 expected no update pending");
          end else begin
            cur_exp = exp_q.pop_front();
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    frame_pos++;
  endtask

  // Advance until frame_done is visible; frame_pos 0 is then the first
  // cycle of a new frame.
  task automatic waitFd();
    int guard;
    guard = 0;
    while (!frame_done && guard < 100) begin
      step();
      guard++;
    end
    if (!frame_done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL wait_frame_done: got no frame_done expected one within 100 cycles");
    end
    frame_pos = 0;
  endtask

  task automatic loadAt(input logic [15:0] v, input logic [3:0] d, input int pos);
    while (frame_pos < pos) step();
    value = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic blz,
                               input int pos, input logic has_pre, input logic [15:0] pre_v,
                               input int pre_pos, input frame_t exp);
    waitFd();
    if (has_pre) loadAt(pre_v, 4'b0000, pre_pos);
    loadAt(v, d, pos);
    exp_q.push_back(exp);
    waitFd();
    blank_lz = blz;
    step();
    waitFd();
  endtask

  task automatic releaseAndCheck(input string name);
    rst = 1'b0;
    checkOutput({name, "_c0"}, 7'b0000000, 1'b0, 4'b0000, 1'b0, 1'b0);
    step();
    checkOutput({name, "_c1"}, 7'b0000000, 1'b0, 4'b0000, 1'b0, 1'b0);
    step();
    checkOutput({name, "_c2"}, 7'b0000000, 1'b0, 4'b0000, 1'b0, 1'b0);
    step();
    checkOutput({name, "_c3"}, 7'b1111110, 1'b0, 4'b0001, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 7'b0000000, 1'b0, 4'b0000, 1'b0, 1'b0);
    releaseAndCheck("release");

    applyStimulus(16'h1234, 4'b0101, 1'b0, 13, 1'b0, 16'h0, 0,
      mkRec(16'h1234, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b1111, 4'b0101));
    applyStimulus(16'hAFB0, 4'b1000, 1'b0, 5, 1'b0, 16'h0, 0,
      mkRec(16'hAFB0, {7'b1110111, 7'b1000111, 7'b0011111, 7'b1111110}, 4'b1111, 4'b1000));
    applyStimulus(16'h0007, 4'b0110, 1'b1, 20, 1'b0, 16'h0, 0,
      mkRec(16'h0007, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1110000}, 4'b0001, 4'b0000));
    applyStimulus(16'h0000, 4'b0001, 1'b1, 9, 1'b0, 16'h0, 0,
      mkRec(16'h0000, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0001, 4'b0001));
    applyStimulus(16'h0102, 4'b1010, 1'b1, 2, 1'b0, 16'h0, 0,
      mkRec(16'h0102, {7'b0000000, 7'b0110000, 7'b1111110, 7'b1101101}, 4'b0111, 4'b0010));
    applyStimulus(16'h6666, 4'b0000, 1'b0, 21, 1'b1, 16'h5555, 11,
      mkRec(16'h6666, {4{7'b1011111}}, 4'b1111, 4'b0000));
    applyStimulus(16'h9999, 4'b0000, 1'b0, 31, 1'b0, 16'h0, 0,
      mkRec(16'h9999, {4{7'b1111011}}, 4'b1111, 4'b0000));
    applyStimulus(16'h0008, 4'b0000, 1'b0, 7, 1'b0, 16'h0, 0,
      mkRec(16'h0008, {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111111}, 4'b1111, 4'b0000));

    waitFd();
    loadAt(16'h4321, 4'b1111, 16);
    rst = 1'b1;
    blank_lz = 1'b0;
    step();
    step();
    checkOutput("midframe_reset", 7'b0000000, 1'b0, 4'b0000, 1'b0, 1'b0);
    releaseAndCheck("rerelease");
    step();
    waitFd();
    step();
    waitFd();

    cmp("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
